// File: rtl/multitap_entry_ctrl_if.sv
// Keypad / commit bus between the scanner, the multi-tap entry controller
// and the message buffer. The controller is the slave side; the keypad and
// downstream logic together form the master side.
interface multitap_entry_ctrl_if #(
  parameter int KEYW = 8,
  parameter int TW   = 2
);
  logic            strobe;
  logic [KEYW-1:0] keycode;
  logic            commit_ready;
  logic            mode;
  logic            upper;
  logic            pend_valid;
  logic [KEYW-1:0] pend_key;
  logic [TW-1:0]   tap_count;
  logic            commit_valid;
  logic [KEYW-1:0] commit_key;
  logic [TW-1:0]   commit_tap;
  logic            commit_mode;
  logic            commit_upper;
  logic            msg_tx_ctrl;
  logic            overflow;

  modport master (
    output strobe, keycode, commit_ready,
    input  mode, upper, pend_valid, pend_key, tap_count,
    input  commit_valid, commit_key, commit_tap, commit_mode, commit_upper,
    input  msg_tx_ctrl, overflow
  );

  modport slave (
    input  strobe, keycode, commit_ready,
    output mode, upper, pend_valid, pend_key, tap_count,
    output commit_valid, commit_key, commit_tap, commit_mode, commit_upper,
    output msg_tx_ctrl, overflow
  );
endinterface

// File: rtl/multitap_entry_ctrl.sv
// Multi-tap keypad text-entry controller. Tracks the pending key and tap
// index, auto-commits after an idle timeout, handles mode/shift/clear/send
// keys and hands committed characters to a one-entry valid/ready register.
module multitap_entry_ctrl #(
  parameter int              KEYW          = 8,
  parameter int              TAP_MAX       = 4,
  parameter int              TIMEOUT       = 50000000,
  parameter bit              SHIFT_ONESHOT = 1'b0,
  parameter logic [KEYW-1:0] KEY_MODE      = 'h28,
  parameter logic [KEYW-1:0] KEY_SHIFT     = 'h84,
  parameter logic [KEYW-1:0] KEY_CLEAR     = 'h48,
  parameter logic [KEYW-1:0] KEY_SEND      = 'h88
) (
  input  logic                  clk,
  input  logic                  nrst,
  multitap_entry_ctrl_if.slave  bus
);

  localparam int TW  = (TAP_MAX > 1) ? $clog2(TAP_MAX) : 1;
  localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t          state;
  logic            mode_r;
  logic            upper_r;
  logic            pend_valid_r;
  logic [KEYW-1:0] pend_key_r;
  logic [TW-1:0]   tap_r;
  logic [TMW-1:0]  timer_r;
  logic            commit_valid_r;
  logic [KEYW-1:0] commit_key_r;
  logic [TW-1:0]   commit_tap_r;
  logic            commit_mode_r;
  logic            commit_upper_r;
  logic            msg_tx_r;
  logic            overflow_r;

  logic is_mode, is_shift, is_clear, is_send, is_char;
  logic same_key, stalled, timeout_hit, need_commit, drop, do_commit;

  // Decode the incoming strobe and decide whether it commits, stalls or drops.
  always_comb begin
    is_mode     = (bus.keycode == KEY_MODE);
    is_shift    = (bus.keycode == KEY_SHIFT);
    is_clear    = (bus.keycode == KEY_CLEAR);
    is_send     = (bus.keycode == KEY_SEND);
    is_char     = !(is_mode || is_shift || is_clear || is_send);
    same_key    = pend_valid_r && (bus.keycode == pend_key_r);
    stalled     = commit_valid_r && !bus.commit_ready;
    timeout_hit = (state == PEND) && !bus.strobe && (timer_r == TMW'(TIMEOUT - 1));
    need_commit = timeout_hit ||
                  (bus.strobe && pend_valid_r &&
                   ((is_char && !same_key) || is_mode || is_shift || is_send));
    drop        = bus.strobe && need_commit && stalled;
    do_commit   = need_commit && !stalled;
  end

  // Entry FSM, tap/timer tracking and commit holding register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      mode_r         <= 1'b0;
      upper_r        <= 1'b0;
      pend_valid_r   <= 1'b0;
      pend_key_r     <= '0;
      tap_r          <= '0;
      timer_r        <= '0;
      commit_valid_r <= 1'b0;
      commit_key_r   <= '0;
      commit_tap_r   <= '0;
      commit_mode_r  <= 1'b0;
      commit_upper_r <= 1'b0;
      msg_tx_r       <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      msg_tx_r <= 1'b0;

      // Downstream took the held character; a load below overrides this.
      if (commit_valid_r && bus.commit_ready)
        commit_valid_r <= 1'b0;

      // Mode/upper are captured before any toggle from the same strobe.
      if (do_commit) begin
        commit_valid_r <= 1'b1;
        commit_key_r   <= pend_key_r;
        commit_tap_r   <= tap_r;
        commit_mode_r  <= mode_r;
        commit_upper_r <= upper_r;
        if (SHIFT_ONESHOT)
          upper_r <= 1'b0;
      end

      if (drop) begin
        overflow_r <= 1'b1;
      end else if (bus.strobe) begin
        if (is_clear) begin
          state        <= IDLE;
          pend_valid_r <= 1'b0;
          tap_r        <= '0;
          timer_r      <= '0;
          overflow_r   <= 1'b0;
        end else if (is_mode || is_shift || is_send) begin
          state        <= IDLE;
          pend_valid_r <= 1'b0;
          tap_r        <= '0;
          timer_r      <= '0;
          if (is_mode)
            mode_r <= ~mode_r;
          // A one-shot commit has already cleared upper, so the toggle sets it.
          if (is_shift)
            upper_r <= (SHIFT_ONESHOT && do_commit) ? 1'b1 : ~upper_r;
          if (is_send)
            msg_tx_r <= 1'b1;
        end else if (same_key) begin
          tap_r   <= (tap_r == TW'(TAP_MAX - 1)) ? '0 : tap_r + TW'(1);
          timer_r <= '0;
        end else begin
          state        <= PEND;
          pend_valid_r <= 1'b1;
          pend_key_r   <= bus.keycode;
          tap_r        <= '0;
          timer_r      <= '0;
        end
      end else if (state == PEND) begin
        if (timeout_hit) begin
          // Timer holds at its last value while the commit is stalled.
          if (do_commit) begin
            state        <= IDLE;
            pend_valid_r <= 1'b0;
            tap_r        <= '0;
            timer_r      <= '0;
          end
        end else begin
          timer_r <= timer_r + TMW'(1);
        end
      end
    end
  end

  assign bus.mode         = mode_r;
  assign bus.upper        = upper_r;
  assign bus.pend_valid   = pend_valid_r;
  assign bus.pend_key     = pend_key_r;
  assign bus.tap_count    = tap_r;
  assign bus.commit_valid = commit_valid_r;
  assign bus.commit_key   = commit_key_r;
  assign bus.commit_tap   = commit_tap_r;
  assign bus.commit_mode  = commit_mode_r;
  assign bus.commit_upper = commit_upper_r;
  assign bus.msg_tx_ctrl  = msg_tx_r;
  assign bus.overflow     = overflow_r;

endmodule
